ram16x16_write_scheduler: RTL and testbench

Write-side controller for the 16-row × 16-bit monochrome bitmap RAM that the VGA display path reads. Host writes are buffered in a small FIFO and drained to the RAM write port only while the display is not scanning bitmap rows, so no visible tearing occurs. A bulk-clear sequencer zeroes all 16 rows on request. The block sits between the host/pattern logic and the RAM write port, in the `vga_clk` domain alongside the display controller.

---
 rtl/ram16x16_write_scheduler.sv | 149 ++++++++++++++
 tb/tb_ram16x16_write_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x16_write_scheduler.sv
// Write-side scheduler for the 16x16 bitmap RAM: buffers host writes
// and drains them or bulk-clears the RAM only outside the visible rows.
module ram16x16_write_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 16
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        Ready_Sig,
    input  logic [11:0] Row_Addr_Sig,
    input  logic        wr_req,
    input  logic [3:0]  wr_row,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    input  logic        clr_req,
    output logic        clr_done,
    output logic        busy,
    output logic [2:0]  fifo_count,
    output logic        ram_we,
    output logic [3:0]  ram_waddr,
    output logic [15:0] ram_wdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [19:0]    mem_q [FIFO_DEPTH];
    logic [19:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]     count_q, count_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           win_q, win_d;
    logic           ram_we_q, ram_we_d;
    logic [3:0]     ram_waddr_q, ram_waddr_d;
    logic [15:0]    ram_wdata_q, ram_wdata_d;
    logic           clr_done_q, clr_done_d;
    logic           full;
    logic           push;
    logic           pop;

    assign full       = (count_q == 3'(FIFO_DEPTH));
    assign wr_ack     = wr_req && !full && (state_q != CLEAR) && !clr_req;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_wdata  = ram_wdata_q;
    assign clr_done   = clr_done_q;

    // Write window: open whenever the display is not on a bitmap row.
    always_comb begin
        win_d = !(Ready_Sig && (Row_Addr_Sig < 12'(ROWS)));
    end

    // Next state, FIFO bookkeeping and the registered RAM write port.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        clr_done_d  = 1'b0;
        push        = wr_ack;
        pop         = 1'b0;
        case (state_q)
            CLEAR: begin
                // Stay one extra cycle so busy drops after clr_done.
                if (clr_done_q) begin
                    state_d = IDLE;
                end else if (win_q) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = cnt_q;
                    ram_wdata_d = 16'h0000;
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == 4'(ROWS - 1)) begin
                        clr_done_d = 1'b1;
                    end
                end
            end
            IDLE, DRAIN: begin
                if (clr_req) begin
                    state_d  = CLEAR;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = 3'd0;
                    cnt_d    = 4'd0;
                end else begin
                    pop = win_q && (count_q != 3'd0);
                    if (pop) begin
                        ram_we_d    = 1'b1;
                        ram_waddr_d = mem_q[rd_ptr_q][19:16];
                        ram_wdata_d = mem_q[rd_ptr_q][15:0];
                        rd_ptr_d    = rd_ptr_q + PW'(1);
                    end
                    if (push) begin
                        mem_d[wr_ptr_q] = {wr_row, wr_data};
                        wr_ptr_d        = wr_ptr_q + PW'(1);
                    end
                    count_d = count_q + 3'(push) - 3'(pop);
                    state_d = (count_d != 3'd0) ? DRAIN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= 3'd0;
            cnt_q       <= 4'd0;
            win_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= 4'd0;
            ram_wdata_q <= 16'h0000;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            clr_done_q  <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_ram16x16_write_scheduler.sv
// Directed bench for ram16x16_write_scheduler with a queue-based
// reference model checked every cycle plus hand-computed literals.
module tb_ram16x16_write_scheduler;

    localparam int FD = 4;
    localparam int NR = 16;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        Ready_Sig;
    logic [11:0] Row_Addr_Sig;
    logic        wr_req;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        clr_req;
    logic        clr_done;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        ram_we;
    logic [3:0]  ram_waddr;
    logic [15:0] ram_wdata;

    ram16x16_write_scheduler #(.FIFO_DEPTH(FD), .ROWS(NR)) dut (
        .vga_clk(vga_clk), .rst(rst),
        .Ready_Sig(Ready_Sig), .Row_Addr_Sig(Row_Addr_Sig),
        .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data),
        .wr_ack(wr_ack), .clr_req(clr_req), .clr_done(clr_done),
        .busy(busy), .fifo_count(fifo_count),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    always #5 vga_clk = ~vga_clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  row;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_win;
    logic        m_clearing;
    int          m_cnt;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_done;

    function automatic logic exp_ack();
        return wr_req && (q.size() < FD) && !m_clearing && !clr_req;
    endfunction

    always @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_win      = 1'b0;
            m_clearing = 1'b0;
            m_cnt      = 0;
            exp_we     = 1'b0;
            exp_addr   = 4'd0;
            exp_data   = 16'h0;
            exp_done   = 1'b0;
        end else begin
            logic ack;
            logic we;
            logic dn;
            ent_t e;
            ack = exp_ack();
            we  = 1'b0;
            dn  = 1'b0;
            if (m_clearing) begin
                if (exp_done) begin
                    m_clearing = 1'b0;
                end else if (m_win) begin
                    we       = 1'b1;
                    exp_addr = 4'(m_cnt);
                    exp_data = 16'h0;
                    dn       = (m_cnt == NR - 1);
                    m_cnt++;
                end
            end else if (clr_req) begin
                q.delete();
                m_clearing = 1'b1;
                m_cnt      = 0;
            end else begin
                if (m_win && q.size() > 0) begin
                    e        = q.pop_front();
                    we       = 1'b1;
                    exp_addr = e.row;
                    exp_data = e.data;
                end
                if (ack) begin
                    e.row  = wr_row;
                    e.data = wr_data;
                    q.push_back(e);
                end
            end
            exp_we   = we;
            exp_done = dn;
            m_win    = !(Ready_Sig && Row_Addr_Sig < 12'(NR));
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge vga_clk) begin
        chk("wr_ack", 32'(wr_ack), 32'(exp_ack()));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_waddr", 32'(ram_waddr), 32'(exp_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(exp_data));
        chk("clr_done", 32'(clr_done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(m_clearing || q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    end

    // Write monitor used by the clear and reset scenarios.
    int   nwe = 0;
    logic done_seen = 1'b0;
    logic [3:0] done_addr = 4'd0;
    always @(negedge vga_clk) begin
        if (ram_we) nwe++;
        if (clr_done) begin
            done_seen = 1'b1;
            done_addr = ram_waddr;
        end
    end

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        cyc();
        wr_req  = 1'b1;
        wr_row  = r;
        wr_data = d;
    endtask

    initial begin
        rst = 1'b1;
        Ready_Sig = 1'b0;
        Row_Addr_Sig = 12'd0;
        wr_req = 1'b0;
        wr_row = 4'd0;
        wr_data = 16'h0;
        clr_req = 1'b0;
        repeat (3) cyc();
        @(negedge vga_clk);
        chk("rst ram_we", 32'(ram_we), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // single write with the window open
        push(4'd3, 16'hA5A5);
        @(negedge vga_clk);
        chk("single ack", 32'(wr_ack), 32'd1);
        cyc();
        wr_req = 1'b0;
        @(negedge vga_clk);
        chk("single c1 we", 32'(ram_we), 32'd0);
        cyc();
        @(negedge vga_clk);
        chk("single c2 we", 32'(ram_we), 32'd1);
        chk("single c2 addr", 32'(ram_waddr), 32'd3);
        chk("single c2 data", 32'(ram_wdata), 32'hA5A5);

        // window gating: fill while display scans row 5
        cyc();
        Ready_Sig = 1'b1;
        Row_Addr_Sig = 12'd5;
        cyc();
        for (int i = 0; i < 4; i++) push(4'(4 + i), 16'h1000 + 16'(i));
        push(4'd9, 16'hBEEF);
        @(negedge vga_clk);
        chk("gate 5th ack", 32'(wr_ack), 32'd0);
        chk("gate count", 32'(fifo_count), 32'd4);
        chk("gate no we", 32'(ram_we), 32'd0);
        cyc();
        wr_req = 1'b0;
        Row_Addr_Sig = 12'd16;
        cyc();
        cyc();
        @(negedge vga_clk);
        chk("gate first row", 32'(ram_waddr), 32'd4);
        chk("gate first data", 32'(ram_wdata), 32'h1000);
        repeat (6) cyc();

        // full FIFO with a simultaneous pop
        Row_Addr_Sig = 12'd5;
        cyc();
        for (int i = 0; i < 4; i++) push(4'(8 + i), 16'h2000 + 16'(i));
        cyc();
        wr_req = 1'b0;
        Row_Addr_Sig = 12'd16;
        push(4'd12, 16'hCAFE);
        @(negedge vga_clk);
        chk("full ack0", 32'(wr_ack), 32'd0);
        cyc();
        @(negedge vga_clk);
        chk("full ack1", 32'(wr_ack), 32'd1);
        cyc();
        wr_req = 1'b0;
        repeat (8) cyc();

        // clear with pending entries, window toggling
        Row_Addr_Sig = 12'd5;
        cyc();
        push(4'd1, 16'h1111);
        push(4'd2, 16'h2222);
        cyc();
        clr_req = 1'b1;
        @(negedge vga_clk);
        chk("clr ack", 32'(wr_ack), 32'd0);
        cyc();
        wr_req = 1'b0;
        clr_req = 1'b0;
        nwe = 0;
        done_seen = 1'b0;
        @(negedge vga_clk);
        chk("clr flushed", 32'(fifo_count), 32'd0);
        chk("clr busy", 32'(busy), 32'd1);
        for (int i = 0; i < 120 && !done_seen; i++) begin
            cyc();
            Row_Addr_Sig = ((i / 3) % 2 == 0) ? 12'd20 : 12'd5;
            clr_req = (i == 10);
        end
        clr_req = 1'b0;
        chk("clr done seen", 32'(done_seen), 32'd1);
        chk("clr writes", 32'(nwe), 32'd16);
        chk("clr done addr", 32'(done_addr), 32'd15);
        cyc();
        @(negedge vga_clk);
        chk("clr busy off", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("clr no restart", 32'(nwe), 32'd16);

        // reset in the middle of a clear
        Ready_Sig = 1'b0;
        cyc();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int i = 0; i < 30 && m_cnt != 7; i++) cyc();
        chk("rst mid cnt", 32'(m_cnt), 32'd7);
        rst = 1'b1;
        @(negedge vga_clk);
        chk("rst mid we", 32'(ram_we), 32'd0);
        chk("rst mid addr", 32'(ram_waddr), 32'd0);
        chk("rst mid data", 32'(ram_wdata), 32'd0);
        chk("rst mid done", 32'(clr_done), 32'd0);
        chk("rst mid busy", 32'(busy), 32'd0);
        cyc();
        rst = 1'b0;
        nwe = 0;
        repeat (10) cyc();
        chk("rst no we", 32'(nwe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
